// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   arb_state_t    : arbiter FSM states (IDLE, OWNED)
//   onehot_to_idx  : binary index of the lowest set bit of a one-hot vector (up to 32 bits)
//   wrap_inc       : (idx + 1) mod n without assuming n is a power of two
package rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    OWNED
  } arb_state_t;

  function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_ctrl_if.sv
// Request/grant bus between the requesters and the round-robin arbiter.
//   req         : request vector, bit i = requester i
//   done        : release pulse from the current owner
//   grant       : one-hot grant
//   grant_valid : high while a grant is held
//   grant_idx   : binary index of the owner
//   timeout     : one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_ctrl_if #(
  parameter int unsigned W_DATA = 5
);
  localparam int unsigned IW = $clog2(W_DATA);

  logic [W_DATA-1:0] req;
  logic              done;
  logic [W_DATA-1:0] grant;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
  logic              timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  grant_idx,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output grant_idx,
    output timeout
  );
endinterface

// File: rtl/rr_rotate_pick.sv
// Combinational round-robin pick: rotates req right by ptr, takes the lowest set bit k
// of the rotated vector and maps it back to winner = (ptr + k) mod W_DATA.
//   req     : request vector
//   ptr     : current priority pointer (highest-priority requester)
//   winner  : index of the selected requester (meaningless when any_req = 0)
//   any_req : at least one request is active
module rr_rotate_pick #(
  parameter int unsigned W_DATA = 5
) (
  input  logic [W_DATA-1:0]         req,
  input  logic [$clog2(W_DATA)-1:0] ptr,
  output logic [$clog2(W_DATA)-1:0] winner,
  output logic                      any_req
);
  localparam int unsigned IW = $clog2(W_DATA);

  logic [2*W_DATA-1:0] doubled;
  logic [W_DATA-1:0]   rotated;
  int unsigned         k;
  int unsigned         sum;

  always_comb begin
    // Shifting a doubled copy gives a rotate for any W_DATA, not only powers of two.
    doubled = {req, req} >> ptr;
    rotated = doubled[W_DATA-1:0];
    any_req = |rotated;
    k = 0;
    for (int i = W_DATA - 1; i >= 0; i--) begin
      if (rotated[i]) k = unsigned'(i);
    end
    sum = 32'(ptr) + k;
    if (sum >= W_DATA) sum = sum - W_DATA;
    winner = IW'(sum);
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Sequential round-robin arbiter for W_DATA requesters sharing one resource.
// A grant is held until the owner pulses done or drops its request; the pointer then
// moves past the owner and the next winner is granted on the following edge.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rr_arbiter_ctrl_if.slave (req, done in; grant, grant_valid, grant_idx, timeout out)
// Optional feature macro: RR_ARB_TIMEOUT_EN -- adds a hold counter that forces release after
// MAX_HOLD owned cycles and pulses timeout; without it timeout is tied to 0.
module rr_arbiter_ctrl
  import rr_arb_pkg::*;
#(
  parameter int unsigned W_DATA   = 5,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  rr_arbiter_ctrl_if.slave bus
);
  localparam int unsigned IW = $clog2(W_DATA);

  if (W_DATA < 2 || W_DATA > 32 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_arbiter_ctrl: W_DATA must be 2..32 and MAX_HOLD >= 1");
  end

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W_DATA-1:0] grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [IW-1:0]     pick_ptr;
  logic [IW-1:0]     winner;
  logic              any_req;
  logic              rel;
  logic              forced;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`endif

  // One picker serves both the IDLE pick and the release pick; on release the pointer is
  // already one past the owner, which leaves the owner's bit at lowest priority.
  rr_rotate_pick #(
    .W_DATA (W_DATA)
  ) u_pick (
    .req     (bus.req),
    .ptr     (pick_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    valid_d = valid_q;
    forced  = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
    forced    = (state_q == OWNED) && (hold_q == HW'(MAX_HOLD - 1));
`endif
    rel      = bus.done | ~bus.req[idx_q] | forced;
    pick_ptr = (state_q == OWNED) ? IW'(wrap_inc(32'(idx_q), W_DATA)) : ptr_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = OWNED;
          grant_d = W_DATA'(1) << winner;
          idx_d   = winner;
          valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      OWNED: begin
        if (rel) begin
          ptr_d = pick_ptr;
`ifdef RR_ARB_TIMEOUT_EN
          // Only flag a timeout when the owner was not already letting go.
          timeout_d = forced & ~bus.done & bus.req[idx_q];
          hold_d    = '0;
`endif
          if (any_req) begin
            grant_d = W_DATA'(1) << winner;
            idx_d   = winner;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_d = hold_q + HW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Self-checking bench for rr_arbiter_ctrl (W_DATA=5, MAX_HOLD=4).
// A table of {inputs, expected outputs} rows is applied one clock each; expected values are
// queued when a row is driven and popped/compared one edge later. A hand-written sequence
// covers the long-hold case, whose expectation depends on RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] req;
    logic       done;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_to;
  } vec_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  exp_t sb[$];
  vec_t tbl[26];

  always #5 clk = ~clk;

  rr_arbiter_ctrl_if #(.W_DATA(5)) bus ();

  rr_arbiter_ctrl #(
    .W_DATA   (5),
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic d,
                              input logic v, input logic [2:0] idx, input logic to);
    vec_t t;
    t.rst = r; t.req = rq; t.done = d; t.exp_valid = v; t.exp_idx = idx; t.exp_to = to;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, step_no, act, want);
    end
  endtask

  task automatic check_out();
    exp_t       e;
    logic [4:0] one;
    logic [4:0] eg;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard step %0d: got empty queue want entry", step_no);
      return;
    end
    total--;
    e   = sb.pop_front();
    one = 5'b00001;
    eg  = e.valid ? (one << e.idx) : 5'b00000;
    cmp("grant",       32'(bus.grant),       32'(eg));
    cmp("grant_valid", 32'(bus.grant_valid), 32'(e.valid));
    cmp("grant_idx",   32'(bus.grant_idx),   32'(e.idx));
    cmp("timeout",     32'(bus.timeout),     32'(e.to));
  endtask

  task automatic step(input logic r, input logic [4:0] rq, input logic d, input exp_t e);
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
    step_no++;
  endtask

  initial begin
    exp_t e;
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;

    // Reset, full rotation with done every cycle, wrap at W_DATA-1.
    tbl[0]  = mk(1, 5'b00000, 0, 0, 0, 0);
    tbl[1]  = mk(0, 5'b11111, 0, 1, 0, 0);
    tbl[2]  = mk(0, 5'b11111, 1, 1, 1, 0);
    tbl[3]  = mk(0, 5'b11111, 1, 1, 2, 0);
    tbl[4]  = mk(0, 5'b11111, 1, 1, 3, 0);
    tbl[5]  = mk(0, 5'b11111, 1, 1, 4, 0);
    tbl[6]  = mk(0, 5'b11111, 1, 1, 0, 0);
    tbl[7]  = mk(0, 5'b11111, 1, 1, 1, 0);
    tbl[8]  = mk(0, 5'b11111, 1, 1, 2, 0);
    tbl[9]  = mk(0, 5'b11111, 1, 1, 3, 0);
    tbl[10] = mk(0, 5'b11111, 1, 1, 4, 0);
    // Owner 4 releases with 10001: ptr wraps to 0 -> idx 0, then release -> idx 4.
    tbl[11] = mk(0, 5'b10001, 1, 1, 0, 0);
    tbl[12] = mk(0, 5'b10001, 1, 1, 4, 0);
    tbl[13] = mk(0, 5'b10001, 0, 1, 4, 0);
    tbl[14] = mk(0, 5'b11111, 0, 1, 4, 0);
    // Request drop hands over; done ignored while idle; done + drop is one release.
    tbl[15] = mk(1, 5'b00000, 0, 0, 0, 0);
    tbl[16] = mk(0, 5'b00010, 0, 1, 1, 0);
    tbl[17] = mk(0, 5'b01000, 0, 1, 3, 0);
    tbl[18] = mk(0, 5'b00000, 0, 0, 0, 0);
    tbl[19] = mk(0, 5'b00000, 1, 0, 0, 0);
    tbl[20] = mk(0, 5'b00001, 1, 1, 0, 0);
    tbl[21] = mk(0, 5'b00000, 1, 0, 0, 0);
    tbl[22] = mk(0, 5'b00011, 0, 1, 1, 0);
    // Reset mid-ownership with ptr at 2 returns ptr to 0.
    tbl[23] = mk(0, 5'b01000, 0, 1, 3, 0);
    tbl[24] = mk(1, 5'b01010, 0, 0, 0, 0);
    tbl[25] = mk(0, 5'b01010, 0, 1, 1, 0);

    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      e.valid = tbl[i].exp_valid;
      e.idx   = tbl[i].exp_idx;
      e.to    = tbl[i].exp_to;
      step(tbl[i].rst, tbl[i].req, tbl[i].done, e);
    end

    // Owner 0 never releases with 00011 requesting.
    e = '{valid: 1'b0, idx: 3'd0, to: 1'b0};
    step(1'b1, 5'b00000, 1'b0, e);
    e = '{valid: 1'b1, idx: 3'd0, to: 1'b0};
    step(1'b0, 5'b00011, 1'b0, e);
    for (int i = 1; i <= 20; i++) begin
      e.valid = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
      // Ownership alternates every 4 cycles, each handover flagged.
      e.idx = 3'((i / 4) % 2);
      e.to  = (i % 4 == 0);
`else
      e.idx = 3'd0;
      e.to  = 1'b0;
`endif
      step(1'b0, 5'b00011, 1'b0, e);
    end

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_ctrl.md
# rr_arbiter_ctrl

Sequential round-robin arbiter for N requesters sharing one resource. It holds a rotating priority pointer, rotates the request vector by that pointer, and picks the first active requester. It keeps the grant until the owner releases, then advances the pointer past the owner. It sits in the N-Bit Round Robin Arbiter block, on top of the circular-shift rotator datapath.

## Interface
- W_DATA, 5, number of requesters N; legal range 2..32
- MAX_HOLD, 8, maximum grant cycles before forced release; used only with RR_ARB_TIMEOUT_EN; must be ≥1
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high; one clock, and reset is synchronous and active-high
- req  in  W_DATA  request vector; bit i = requester i
- done  in  1  release pulse from the current owner
- grant  out  W_DATA  one-hot grant, registered; all zero when no owner
- grant_valid  out  1  high while any grant bit is set, registered
- grant_idx  out  $clog2(W_DATA)  binary index of the owner; 0 when grant_valid=0
- timeout  out  1  one-cycle pulse on forced release; tied 0 without the macro

## Operation
- State: IDLE / OWNED. Registers: state, ptr[$clog2(W_DATA)], grant, grant_idx, hold_cnt.
- Pick (combinational):
  - rotate req right by ptr;
  - take the lowest set bit k;
  - winner = (ptr + k) mod W_DATA, with explicit wrap and no power-of-2 assumption.
- IDLE:
  - if |req, load grant=onehot(winner) and grant_idx=winner, then go to OWNED;
  - else hold all-zero outputs.
- OWNED: release occurs when done=1, or req[grant_idx]=0, or (macro) hold_cnt==MAX_HOLD-1.
- On release:
  - ptr ← (grant_idx+1) mod W_DATA, so W_DATA-1 wraps to 0;
  - re-run the pick with the new ptr on the same cycle's req, with the owner's bit included at lowest priority;
  - if any req, grant the new winner next cycle (back-to-back, no bubble) and stay in OWNED;
  - else go to IDLE with grant cleared.
- No release: outputs are held and ptr is unchanged. Changes in other req bits are ignored.
- hold_cnt clears on every new grant and increments each OWNED cycle without a release.
- ptr changes only on release, never on a grant from IDLE.
- Reset values: state=IDLE, ptr=0, grant=0, grant_valid=0, grant_idx=0, hold_cnt=0, timeout=0.

## Timing
- Request-to-grant latency: 1 cycle (req sampled at edge n, grant visible after edge n).
- Release-to-next-grant: 1 cycle. The grant switches directly from the old one-hot to the new one.
- grant is never multi-hot, and never zero while grant_valid=1.
- done while IDLE is ignored.
- done and req-drop in the same cycle count as a single release.
- rst asserted mid-ownership: at the next edge, all registers return to reset values and any pending pick is discarded. req is arbitrated starting from the first edge after rst deasserts.
- All requesters active continuously with done every cycle: grants cycle 0,1,2,…,N-1,0.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - hold_cnt and the forced release are present;
  - the owner loses the grant after MAX_HOLD cycles;
  - timeout pulses high on the release cycle's following edge, aligned with the new grant or the idle outputs.
- Undefined:
  - no hold_cnt register;
  - the owner keeps the grant indefinitely;
  - timeout is constant 0.

## Structure
- Package rr_arb_pkg: typedef arb_state_t enum {IDLE, OWNED}; function onehot_to_idx; function wrap_inc(idx, n).
- Sub-module rr_rotate_pick: combinational rotate-by-ptr plus first-set-bit, outputs winner index and any_req. It is instantiated once and used for both the IDLE pick and the release pick.
- Top: FSM, ptr/grant registers, optional hold counter.

## Test plan
- Reset, then req=5'b00100 → grant=5'b00100, grant_idx=2 one cycle later; ptr still 0.
- req=5'b11111 held, done every OWNED cycle → grant_idx sequence 0,1,2,3,4,0 with no idle cycles.
- Owner 4 releases with req=5'b10001 → ptr wraps to 0, next grant idx 0; then release → idx 4.
- Owner 1 drops req[1] while req=5'b01000 → grant moves to idx 3 next cycle; done ignored in IDLE.
- rst pulsed while owner=3 → next cycle grant=0, ptr=0; req=5'b01010 afterwards → idx 1.
- With RR_ARB_TIMEOUT_EN and MAX_HOLD=4: owner 0 never releases, req=5'b00011 → grant moves to idx 1 after 4 cycles with a timeout pulse. Without the macro, grant stays at idx 0 for 20 cycles.
